// File: rtl/maze_game_sequencer.sv
// maze_game_sequencer: game flow for the maze display (motion gating, collisions, lives, timer, background)
// Ports:
//   clk, rst (async, active-low)
//   frame_end  1-cycle end-of-frame pulse from the VGA sync generator
//   start      debounced start button (level); at_goal player in goal region (level)
//   collide    player/obstacle pixel overlap this cycle
//   move_en    1-cycle motion-step strobe; obj_rst 1-cycle return-to-start pulse
//   state      IDLE=0 PLAY=1 HIT=2 WIN=3 OVER=4; lives; elapsed seconds; background RGB444
module maze_game_sequencer #(
    parameter int LIVES      = 3,
    parameter int MOVE_DIV   = 2,
    parameter int HIT_FRAMES = 60,
    parameter int FPS        = 60,
    parameter int TIME_LIMIT = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_end,
    input  logic        start,
    input  logic        collide,
    input  logic        at_goal,
    output logic        move_en,
    output logic        obj_rst,
    output logic [2:0]  state,
    output logic [2:0]  lives,
    output logic [9:0]  elapsed,
    output logic [11:0] background
);
    typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2, WIN = 3'd3, OVER = 3'd4} state_t;
    localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]    MOVE_LAST  = 4'(MOVE_DIV - 1);
    localparam logic [HW-1:0] HIT_LAST   = HW'(HIT_FRAMES - 1);
    localparam logic [FW-1:0] FPS_LAST   = FW'(FPS - 1);
    localparam logic [9:0]    TIME_END   = 10'(TIME_LIMIT);
    state_t        st_q, st_d;
    logic [2:0]    lives_d;
    logic [9:0]    elapsed_d;
    logic [3:0]    move_q, move_d;
    logic [HW-1:0] hit_q, hit_d;
    logic [FW-1:0] fps_q, fps_d;
    logic          start_q, hit_seen_q, hit_seen_d, move_en_d, obj_rst_d;
    logic          start_rise, hit_any, timing;
    assign start_rise = start & ~start_q;
    // a collision in the frame_end cycle itself still counts for that frame
    assign hit_any    = hit_seen_q | collide;
    assign timing     = frame_end & (st_q == PLAY || st_q == HIT);
    assign state      = st_q;
    assign background = st_q == PLAY ? 12'h0F0 :
                        st_q == HIT  ? 12'hF00 :
                        st_q == WIN  ? 12'h00F :
                        st_q == OVER ? 12'hF0F : 12'hFFF;
    always_comb begin
        st_d       = st_q;
        lives_d    = lives;
        elapsed_d  = elapsed;
        move_d     = move_q;
        hit_d      = hit_q;
        fps_d      = timing ? (fps_q == FPS_LAST ? '0 : fps_q + 1'b1) : fps_q;
        move_en_d  = 1'b0;
        obj_rst_d  = 1'b0;
        hit_seen_d = frame_end ? 1'b0 : hit_seen_q | (collide & (st_q == PLAY));
        if (timing && fps_q == FPS_LAST && elapsed != 10'd999)
            elapsed_d = elapsed + 10'd1;
        case (st_q)
            IDLE: if (start_rise) begin
                st_d      = PLAY;
                lives_d   = LIVES_INIT;
                elapsed_d = '0;
                fps_d     = '0;
                move_d    = '0;
                obj_rst_d = 1'b1;
            end
            PLAY: if (frame_end) begin
                if (at_goal)
                    st_d = WIN;
                else if (hit_any && lives == 3'd1) begin
                    st_d    = OVER;
                    lives_d = '0;
                end else if (hit_any) begin
                    st_d    = HIT;
                    lives_d = lives - 3'd1;
                    hit_d   = '0;
                end else if (elapsed == TIME_END)
                    st_d = OVER;
                else begin
                    move_d    = move_q == MOVE_LAST ? '0 : move_q + 4'd1;
                    move_en_d = move_q == MOVE_LAST;
                end
            end
            HIT: if (frame_end) begin
                if (hit_q == HIT_LAST) begin
                    st_d      = PLAY;
                    obj_rst_d = 1'b1;
                    move_d    = '0;
                end else
                    hit_d = hit_q + 1'b1;
            end
            WIN, OVER: st_d = start_rise ? IDLE : st_q;
            default: st_d = IDLE;
        endcase
    end
    // start_q resets high so a button held through reset cannot start a game
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q       <= IDLE;
            lives      <= LIVES_INIT;
            elapsed    <= '0;
            move_q     <= '0;
            hit_q      <= '0;
            fps_q      <= '0;
            start_q    <= 1'b1;
            hit_seen_q <= 1'b0;
            move_en    <= 1'b0;
            obj_rst    <= 1'b0;
        end else begin
            st_q       <= st_d;
            lives      <= lives_d;
            elapsed    <= elapsed_d;
            move_q     <= move_d;
            hit_q      <= hit_d;
            fps_q      <= fps_d;
            start_q    <= start;
            hit_seen_q <= hit_seen_d;
            move_en    <= move_en_d;
            obj_rst    <= obj_rst_d;
        end
    end
endmodule

// File: tb/tb_maze_game_sequencer.sv
// tb_maze_game_sequencer: directed and random checks of two sequencer configurations against a rule-level model
module tb_maze_game_sequencer;
    logic        clk = 1'b0;
    logic        rst, frame_end, start, collide, at_goal;
    logic        move_en_a, obj_rst_a, move_en_b, obj_rst_b;
    logic [2:0]  state_a, lives_a, state_b, lives_b;
    logic [9:0]  elapsed_a, elapsed_b;
    logic [11:0] bg_a, bg_b;
    int tests = 0;
    int failed = 0;
    int mv_a = 0;
    int mv0 = 0;
    int m_st[2], m_lv[2], m_el[2], m_fc[2], m_md[2], m_hc[2];
    bit m_mv[2], m_ob[2], m_sq[2], m_hs[2];
    always #5 clk = ~clk;
    maze_game_sequencer dut_a (
        .clk(clk), .rst(rst), .frame_end(frame_end), .start(start), .collide(collide), .at_goal(at_goal),
        .move_en(move_en_a), .obj_rst(obj_rst_a), .state(state_a), .lives(lives_a),
        .elapsed(elapsed_a), .background(bg_a)
    );
    maze_game_sequencer #(.FPS(4), .TIME_LIMIT(2)) dut_b (
        .clk(clk), .rst(rst), .frame_end(frame_end), .start(start), .collide(collide), .at_goal(at_goal),
        .move_en(move_en_b), .obj_rst(obj_rst_b), .state(state_b), .lives(lives_b),
        .elapsed(elapsed_b), .background(bg_b)
    );
    function automatic logic [11:0] colour(input int s);
        return s == 1 ? 12'h0F0 : s == 2 ? 12'hF00 : s == 3 ? 12'h00F : s == 4 ? 12'hF0F : 12'hFFF;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_lv[i] = 3; m_el[i] = 0; m_fc[i] = 0; m_md[i] = 0; m_hc[i] = 0;
            m_mv[i] = 1'b0; m_ob[i] = 1'b0; m_sq[i] = 1'b1; m_hs[i] = 1'b0;
        end
    endtask
    // instance 0: FPS 60, limit 120 s; instance 1: FPS 4, limit 2 s; both 3 lives, 2 frames/step, 60 hit frames
    task automatic step(input int i);
        int fps = (i == 0) ? 60 : 4;
        int limit = (i == 0) ? 120 : 2;
        int st = m_st[i];
        int el = m_el[i];
        bit rise = start && !m_sq[i];
        bit hit = m_hs[i] || collide;
        m_mv[i] = 1'b0;
        m_ob[i] = 1'b0;
        m_sq[i] = start;
        m_hs[i] = !frame_end && (m_hs[i] || (collide && st == 1));
        if (frame_end && (st == 1 || st == 2)) begin
            m_fc[i] = (m_fc[i] + 1) % fps;
            if (m_fc[i] == 0) m_el[i] = (el < 999) ? el + 1 : 999;
        end
        if (st == 0 && rise) begin
            m_st[i] = 1; m_lv[i] = 3; m_el[i] = 0; m_fc[i] = 0; m_md[i] = 0; m_ob[i] = 1'b1;
        end else if (st == 1 && frame_end) begin
            if (at_goal) m_st[i] = 3;
            else if (hit && m_lv[i] == 1) begin m_st[i] = 4; m_lv[i] = 0; end
            else if (hit) begin m_st[i] = 2; m_lv[i]--; m_hc[i] = 0; end
            else if (el == limit) m_st[i] = 4;
            else begin m_md[i] = (m_md[i] + 1) % 2; m_mv[i] = (m_md[i] == 0); end
        end else if (st == 2 && frame_end) begin
            m_hc[i]++;
            if (m_hc[i] == 60) begin m_st[i] = 1; m_ob[i] = 1'b1; m_md[i] = 0; end
        end else if ((st == 3 || st == 4) && rise) m_st[i] = 0;
    endtask
    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else begin
            step(0);
            step(1);
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic compare();
        check("a_state", state_a, m_st[0]);
        check("a_lives", lives_a, m_lv[0]);
        check("a_elapsed", elapsed_a, m_el[0]);
        check("a_move_en", move_en_a, m_mv[0]);
        check("a_obj_rst", obj_rst_a, m_ob[0]);
        check("a_bg", bg_a, colour(m_st[0]));
        check("b_state", state_b, m_st[1]);
        check("b_lives", lives_b, m_lv[1]);
        check("b_elapsed", elapsed_b, m_el[1]);
        check("b_move_en", move_en_b, m_mv[1]);
        check("b_obj_rst", obj_rst_b, m_ob[1]);
        check("b_bg", bg_b, colour(m_st[1]));
    endtask
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        if (move_en_a) mv_a++;
        compare();
    endtask
    task automatic frame(input int gap, input bit col, input bit goal);
        for (int k = 0; k < gap; k++) begin
            collide = col && (k == gap / 2);
            cyc();
        end
        collide = 1'b0;
        frame_end = 1'b1;
        at_goal = goal;
        cyc();
        frame_end = 1'b0;
        at_goal = 1'b0;
    endtask
    initial begin
        rst = 1'b0; frame_end = 1'b0; start = 1'b0; collide = 1'b0; at_goal = 1'b0;
        model_reset();
        repeat (3) cyc();
        check("rst_state", state_a, 0);
        check("rst_lives", lives_a, 3);
        check("rst_elapsed", elapsed_a, 0);
        check("rst_bg", bg_a, 12'hFFF);
        rst = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        check("t1_play", state_a, 1);
        check("t1_obj_rst", obj_rst_a, 1);
        start = 1'b0;
        mv0 = mv_a;
        repeat (8) frame(3, 1'b0, 1'b0);
        check("t5_elapsed", elapsed_b, 2);
        check("t5_still_play", state_b, 1);
        frame(3, 1'b0, 1'b0);
        check("t5_over", state_b, 4);
        check("t5_bg", bg_b, 12'hF0F);
        frame(3, 1'b0, 1'b0);
        check("t1_moves", mv_a - mv0, 5);
        frame(4, 1'b1, 1'b0);
        check("t2_hit", state_a, 2);
        check("t2_lives", lives_a, 2);
        mv0 = mv_a;
        repeat (59) frame(1, 1'b0, 1'b0);
        check("t2_still_hit", state_a, 2);
        frame(1, 1'b0, 1'b0);
        check("t2_back", state_a, 1);
        check("t2_obj_rst", obj_rst_a, 1);
        check("t2_no_move", mv_a - mv0, 0);
        frame(2, 1'b1, 1'b0);
        check("t3_hit2", state_a, 2);
        check("t3_lives1", lives_a, 1);
        repeat (60) frame(1, 1'b0, 1'b0);
        check("t3_back", state_a, 1);
        frame(2, 1'b1, 1'b0);
        check("t3_over", state_a, 4);
        check("t3_lives0", lives_a, 0);
        start = 1'b1;
        cyc();
        check("t3_idle", state_a, 0);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        check("t3_replay", state_a, 1);
        check("t3_relives", lives_a, 3);
        start = 1'b0;
        cyc();
        frame(3, 1'b1, 1'b1);
        check("t4_win", state_a, 3);
        check("t4_lives", lives_a, 3);
        check("t4_bg", bg_a, 12'h00F);
        repeat (5) frame(2, 1'b0, 1'b0);
        check("t4_frozen", elapsed_a, 0);
        check("t4_hold", state_a, 3);
        for (int k = 0; k < 4000; k++) begin
            frame_end = ($urandom_range(3) == 0);
            collide = ($urandom_range(39) == 0);
            at_goal = ($urandom_range(199) == 0);
            if ($urandom_range(49) == 0) start = ~start;
            cyc();
        end
        frame_end = 1'b0; collide = 1'b0; at_goal = 1'b0; start = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        check("t6_play", state_a, 1);
        start = 1'b0;
        frame(2, 1'b1, 1'b0);
        check("t6_hit", state_a, 2);
        start = 1'b1;
        cyc();
        check("t6_start_ignored", state_a, 2);
        rst = 1'b0;
        #1;
        check("t6_async_state", state_a, 0);
        check("t6_async_lives", lives_a, 3);
        check("t6_async_move", move_en_a, 0);
        cyc();
        cyc();
        rst = 1'b1;
        repeat (3) cyc();
        check("t6_held_idle", state_a, 0);
        check("t6_no_obj_rst", obj_rst_a, 0);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        check("t6_restart", state_a, 1);
        start = 1'b0;
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
